// File: rtl/text_overlay_pkg.sv
// Shared constants, FSM encoding and helpers for the text overlay.
package text_overlay_pkg;

  localparam int CELL_W      = 8;
  localparam int CELL_H      = 16;
  localparam int CHAR_W      = 7;
  localparam int FONT_ADDR_W = 11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Ceiling log2, never less than 1 so a single-cell buffer still has an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/font_rom.sv
// Synchronous glyph ROM, address {char_code, glyph_row}, one cycle of latency.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  always_ff @(posedge clk) begin
    case (addr)
      // 'J'
      11'h4A2: data <= 8'h1E;
      11'h4A3: data <= 8'h0C;
      11'h4A4: data <= 8'h0C;
      11'h4A5: data <= 8'h0C;
      11'h4A6: data <= 8'h0C;
      11'h4A7: data <= 8'h0C;
      11'h4A8: data <= 8'hCC;
      11'h4A9: data <= 8'hCC;
      11'h4AA: data <= 8'hCC;
      11'h4AB: data <= 8'h78;
      // 'M'
      11'h4D2: data <= 8'hC3;
      11'h4D3: data <= 8'hE7;
      11'h4D4: data <= 8'hFF;
      11'h4D5: data <= 8'hFF;
      11'h4D6: data <= 8'hDB;
      11'h4D7: data <= 8'hC3;
      11'h4D8: data <= 8'hC3;
      11'h4D9: data <= 8'hC3;
      11'h4DA: data <= 8'hC3;
      11'h4DB: data <= 8'hC3;
      default: data <= 8'h00;
    endcase
  end

endmodule

// File: rtl/text_overlay_gen_char_buffer.sv
// Character buffer: one write port, one registered read port, read-first on collision.
module char_buffer #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/text_overlay_gen.sv
// Text overlay: writable character buffer with clear sequencer, blink attribute
// and a 3-cycle pixel pipeline feeding the RGB output mux.
module text_overlay_gen
  import text_overlay_pkg::*;
#(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 4,
  parameter int         ORIGIN_COL = 8,
  parameter int         ORIGIN_ROW = 15,
  parameter int         BLINK_LOG2 = 5,
  parameter logic [2:0] BLANK_RGB  = 3'b000,
  localparam int        ADDR_W     = clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              frame_tick,
  input  logic [2:0]        fg_rgb,
  input  logic [2:0]        bg_rgb,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_err,
  output logic [2:0]        rgb_text,
  output logic              text_on,
  output logic              font_bit
);

  localparam int                XS        = $clog2(CELL_W);
  localparam int                YS        = $clog2(CELL_H);
  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_X   = (ADDR_W + 1)'(CELLS);

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                wr_fire;
  logic                wr_in_range;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [7:0]          ram_wdata;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                phase;

  assign wr_ready    = (state == ST_IDLE) && !clr_req;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < CELLS_X;
  assign phase       = frame_cnt[BLINK_LOG2-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      clr_busy <= 1'b1;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_CELL) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clr_ptr  <= '0;
          end else if (wr_fire && !wr_in_range) begin
            wr_err <= 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // The clear sequencer owns the write port whenever it is running.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = 8'h00;
    end else if (wr_fire && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + BLINK_LOG2'(1);
  end

  // ---- S0: cell lookup, buffer read issued ----
  logic [7:0]        col_s0, row_s0;
  logic              in_win_s0;
  logic [15:0]       lin_s0;
  logic [ADDR_W-1:0] rd_addr_s0;

  // 8-bit subtraction lets a pixel left of / above the window wrap to a large value.
  assign col_s0     = 8'(pixel_x[9:XS]) - 8'(ORIGIN_COL);
  assign row_s0     = 8'(pixel_y[9:YS]) - 8'(ORIGIN_ROW);
  assign in_win_s0  = (col_s0 < 8'(COLS)) && (row_s0 < 8'(ROWS));
  assign lin_s0     = 16'(row_s0) * 16'(COLS) + 16'(col_s0);
  assign rd_addr_s0 = in_win_s0 ? lin_s0[ADDR_W-1:0] : '0;

  logic [7:0] cell_p0;

  char_buffer #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_char_buffer (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr_s0),
    .rd_data (cell_p0)
  );

  logic          vld_p0, in_win_p0;
  logic [YS-1:0] row_px_p0;
  logic [XS-1:0] bitx_p0;

  // ---- S1: glyph fetch ----
  logic [FONT_ADDR_W-1:0] font_addr_p0;
  logic [7:0]             font_p1;
  logic                   vld_p1, in_win_p1, blink_p1;
  logic [XS-1:0]          bitx_p1;

  assign font_addr_p0 = {cell_p0[CHAR_W-1:0], row_px_p0};

  font_rom u_font_rom (
    .clk  (clk),
    .addr (font_addr_p0),
    .data (font_p1)
  );

  // ---- S2: pixel colour select ----
  logic       pix_bit;
  logic [2:0] pix_rgb;

  assign pix_bit = font_p1[~bitx_p1] & in_win_p1 & ~(blink_p1 & phase);

  always_comb begin
    pix_rgb = bg_rgb;
    if (!vld_p1)     pix_rgb = BLANK_RGB;
    else if (pix_bit) pix_rgb = fg_rgb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      in_win_p0 <= 1'b0;
      vld_p1    <= 1'b0;
      in_win_p1 <= 1'b0;
      rgb_text  <= BLANK_RGB;
      text_on   <= 1'b0;
      font_bit  <= 1'b0;
    end else begin
      vld_p0    <= video_on;
      in_win_p0 <= in_win_s0;
      vld_p1    <= vld_p0;
      in_win_p1 <= in_win_p0;
      rgb_text  <= pix_rgb;
      text_on   <= in_win_p1 & vld_p1;
      font_bit  <= pix_bit;
    end
  end

  always_ff @(posedge clk) begin
    row_px_p0 <= pixel_y[YS-1:0];
    bitx_p0   <= pixel_x[XS-1:0];
    bitx_p1   <= bitx_p0;
    blink_p1  <= cell_p0[7];
  end

endmodule

// File: tb/tb_text_overlay_gen.sv
// Directed bench for text_overlay_gen: clear timing, glyph rendering, blink,
// write errors, clear/reset interplay and video blanking.
module tb_text_overlay_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b1;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       frame_tick = 1'b0;
  logic [2:0] fg_rgb = 3'b010;
  logic [2:0] bg_rgb = 3'b001;

  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_addr = 7'd0;
  logic [7:0] wr_data = 8'd0;
  logic       clr_req = 1'b0;
  logic       clr_busy, wr_err, text_on, font_bit;
  logic [2:0] rgb_text;

  logic       wr_valid2 = 1'b0;
  logic       wr_ready2;
  logic [7:0] wr_addr2 = 8'd0;
  logic [7:0] wr_data2 = 8'd0;
  logic       clr_busy2, wr_err2, text_on2, font_bit2;
  logic [2:0] rgb_text2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] j_glyph [16] = '{8'h00, 8'h00, 8'h1E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
                               8'hCC, 8'hCC, 8'hCC, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};

  text_overlay_gen #(.COLS(32), .ROWS(4)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_err(wr_err),
    .rgb_text(rgb_text), .text_on(text_on), .font_bit(font_bit)
  );

  // 25x8 = 200 cells gives an 8-bit address, so out-of-range writes are expressible.
  text_overlay_gen #(.COLS(25), .ROWS(8)) dut2 (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .clr_req(1'b0), .clr_busy(clr_busy2), .wr_err(wr_err2),
    .rgb_text(rgb_text2), .text_on(text_on2), .font_bit(font_bit2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_px(input int x, input int y, input logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
  endtask

  task automatic check_px(input string tag, input logic [2:0] rgb, input logic on, input logic b);
    check({tag, "_rgb"}, 32'(rgb_text), 32'(rgb));
    check({tag, "_on"},  32'(text_on),  32'(on));
    check({tag, "_bit"}, 32'(font_bit), 32'(b));
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic wait_clear(output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (wr_ready) begin
        cyc = c;
        break;
      end
      if (clr_busy !== 1'b1) bad++;
    end
  endtask

  int c1, c2, bad1, bad2;
  logic exp_bit;

  initial begin
    set_px(67, 242, 1'b1);
    tick(3);
    check("rst_busy",   32'(clr_busy), 32'd1);
    check("rst_ready",  32'(wr_ready), 32'd0);
    check("rst_rgb",    32'(rgb_text), 32'd0);
    check("rst_texton", 32'(text_on),  32'd0);
    check("rst_fbit",   32'(font_bit), 32'd0);
    check("rst_wrerr",  32'(wr_err),   32'd0);

    reset = 1'b0;
    c1 = 0; c2 = 0; bad1 = 0; bad2 = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c1 == 0 && wr_ready) c1 = c;
      else if (c1 == 0 && clr_busy !== 1'b1) bad1++;
      if (c2 == 0 && wr_ready2) c2 = c;
      else if (c2 == 0 && clr_busy2 !== 1'b1) bad2++;
      if (c1 != 0 && c2 != 0) break;
    end
    check("clr_len",       32'(c1), 32'd128);
    check("clr_len2",      32'(c2), 32'd200);
    check("clr_busy_hold", 32'(bad1 + bad2), 32'd0);
    check("clr_done",      32'(clr_busy), 32'd0);

    set_px(64, 240, 1'b1);  tick(3); check_px("blank_tl", 3'b001, 1'b1, 1'b0);
    set_px(319, 303, 1'b1); tick(3); check_px("blank_br", 3'b001, 1'b1, 1'b0);
    set_px(63, 240, 1'b1);  tick(3); check_px("left_out", 3'b001, 1'b0, 1'b0);
    set_px(64, 239, 1'b1);  tick(3); check_px("top_out",  3'b001, 1'b0, 1'b0);
    set_px(320, 240, 1'b1); tick(3); check_px("right_out", 3'b001, 1'b0, 1'b0);

    check("wr_ready_idle", 32'(wr_ready), 32'd1);
    do_write(7'd0, 8'h4A);
    check("wr_err_inrange", 32'(wr_err), 32'd0);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 8; x++) begin
        set_px(64 + x, 240 + y, 1'b1);
        tick(3);
        exp_bit = j_glyph[y][7 - x];
        check($sformatf("j_rgb_%0d_%0d", x, y), 32'(rgb_text), exp_bit ? 32'd2 : 32'd1);
        check($sformatf("j_bit_%0d_%0d", x, y), 32'(font_bit), 32'(exp_bit));
        check($sformatf("j_on_%0d_%0d", x, y),  32'(text_on),  32'd1);
      end
    end

    set_px(66, 242, 1'b1); tick(3); check_px("lat_pre", 3'b001, 1'b1, 1'b0);
    set_px(67, 242, 1'b1); tick(2);
    check("lat_2cyc", 32'(rgb_text), 32'd1);
    tick();
    check("lat_3cyc", 32'(rgb_text), 32'd2);

    do_write(7'd1, 8'hCD);
    set_px(72, 242, 1'b1); tick(3); check_px("blink_f0", 3'b010, 1'b1, 1'b1);
    pulse_frames(15); tick(3); check_px("blink_f15", 3'b010, 1'b1, 1'b1);
    pulse_frames(1);  tick(3); check_px("blink_f16", 3'b001, 1'b1, 1'b0);
    set_px(67, 242, 1'b1); tick(3); check_px("noblink_f16", 3'b010, 1'b1, 1'b1);
    set_px(72, 242, 1'b1);
    pulse_frames(15); tick(3); check_px("blink_f31", 3'b001, 1'b1, 1'b0);
    pulse_frames(1);  tick(3); check_px("blink_f32", 3'b010, 1'b1, 1'b1);

    check("wr_ready2", 32'(wr_ready2), 32'd1);
    wr_valid2 = 1'b1; wr_addr2 = 8'd200; wr_data2 = 8'h4A;
    tick();
    wr_valid2 = 1'b0;
    check("oor_err_pulse",   32'(wr_err2),   32'd1);
    check("oor_ready_after", 32'(wr_ready2), 32'd1);
    tick();
    check("oor_err_clear", 32'(wr_err2), 32'd0);
    wr_valid2 = 1'b1; wr_addr2 = 8'd199; wr_data2 = 8'h00;
    tick();
    wr_valid2 = 1'b0;
    check("last_cell_no_err", 32'(wr_err2), 32'd0);
    set_px(67, 242, 1'b1); tick(3);
    check("oor_nochange", 32'(rgb_text2), 32'd1);

    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 7'd2; wr_data = 8'h4A;
    #1;
    check("clr_blocks_wr", 32'(wr_ready), 32'd0);
    tick();
    clr_req = 1'b0; wr_valid = 1'b0;
    check("clr_busy_start", 32'(clr_busy), 32'd1);
    wait_clear(c1, bad1);
    check("clr_req_len",  32'(c1),   32'd128);
    check("clr_req_hold", 32'(bad1), 32'd0);
    set_px(67, 242, 1'b1); tick(3); check_px("cleared_cell0", 3'b001, 1'b1, 1'b0);
    set_px(83, 242, 1'b1); tick(3); check_px("cell2_untaken", 3'b001, 1'b1, 1'b0);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(49);
    reset = 1'b1;
    tick();
    check("mid_rst_busy",  32'(clr_busy), 32'd1);
    check("mid_rst_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    wait_clear(c1, bad1);
    check("mid_rst_len", 32'(c1), 32'd128);

    do_write(7'd0, 8'h4A);
    set_px(67, 242, 1'b1); tick(3); check_px("von_on", 3'b010, 1'b1, 1'b1);
    set_px(67, 242, 1'b0); tick(2);
    check("von_lat_2cyc", 32'(rgb_text), 32'd2);
    tick();
    check_px("von_off", 3'b000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
